// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// tx_state_e encodes the transmit FSM; cnt_bits sizes counters with a 1-bit floor.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP_ST = 2'd2,
        PARITY = 2'd3
    } tx_state_e;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_GAP   = 2;
    localparam logic [DEF_WIDTH-1:0] PATTERN_10010 = 5'b10010;

    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, left-shift register; msb is the bit currently on the serial line.
// Load has priority over shift; no backpressure (the parent FSM sequences it).
module piso_shreg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = d;
        end else if (shift) begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: word accepted on valid/ready, MSB appears one cycle later, then GAP idle cycles.
// in_ready depends on state only; SEQ_TX_PARITY_EN appends an even-parity cycle after the data bits.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   GAP      = DEF_GAP,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int BW = $clog2(WIDTH);
    localparam int GW = cnt_bits(GAP + 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          par_q, par_d;
    logic          load, shift, msb, last_bit, accept;

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .d     (in_data),
        .msb   (msb)
    );

    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == '0);
    // With GAP==0 the frame's final cycle doubles as the accept window for the next word.
    assign in_ready = (state_q == IDLE) ||
                      ((GAP == 0) && (PAR_EN ? (state_q == PARITY) : last_bit));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        par_d     = par_q;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: ;
            SHIFT: begin
                if (!last_bit) begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (PAR_EN) begin
                    state_d = PARITY;
                end else if (GAP > 0) begin
                    state_d   = GAP_ST;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            PARITY: begin
                if (GAP > 0) begin
                    state_d   = GAP_ST;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP_ST: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Accept can only occur in IDLE or the frame's last cycle, so it overrides the above.
        if (accept) begin
            state_d   = SHIFT;
            bit_cnt_d = BIT_LOAD;
            par_d     = ^in_data;
            load      = 1'b1;
        end
    end

    always_comb begin
        data_out  = IDLE_BIT;
        bit_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            SHIFT: begin
                data_out  = msb;
                bit_valid = 1'b1;
                done      = last_bit && !PAR_EN;
            end
            PARITY: begin
                data_out = par_q;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed frames plus randomized traffic against a queue-of-expected-cycles model.
module tb_seq_pattern_tx;
    import seq_tx_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int GA = DEF_GAP;
    localparam int GB = 0;
`ifdef SEQ_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = W + PAR;

    typedef struct packed { logic d; logic v; logic dn; } ent_t;

    logic clk, rst_n;
    logic [W-1:0] din_a, din_b;
    logic vld_a, vld_b;
    logic rdy_a, dout_a, bv_a, busy_a, done_a;
    logic rdy_b, dout_b, bv_b, busy_b, done_b;
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_tx #(.WIDTH(W), .GAP(GA), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(din_a), .in_valid(vld_a), .in_ready(rdy_a),
        .data_out(dout_a), .bit_valid(bv_a), .busy(busy_a), .done(done_a)
    );

    seq_pattern_tx #(.WIDTH(W), .GAP(GB), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(din_b), .in_valid(vld_b), .in_ready(rdy_b),
        .data_out(dout_b), .bit_valid(bv_b), .busy(busy_b), .done(done_b)
    );

    // Packed view {in_ready, data_out, bit_valid, busy, done} of one instance.
    function automatic logic [4:0] obs(input bit sel);
        return sel ? {rdy_b, dout_b, bv_b, busy_b, done_b}
                   : {rdy_a, dout_a, bv_a, busy_a, done_a};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [W-1:0] w);
        if (sel) begin
            din_b = w; vld_b = v;
        end else begin
            din_a = w; vld_a = v;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;
        #12;
        total++;
        if (obs(1'b0) !== 5'b10000) begin
            bad++;
            $display("FAIL reset_hold {rdy,dout,bv,busy,done} got=%b exp=%b", obs(1'b0), 5'b10000);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (obs(s[0]) !== 5'b10000) begin
                bad++;
                $display("FAIL reset_idle sel=%0d got=%b exp=%b", s, obs(s[0]), 5'b10000);
            end
        end
    endtask

    task automatic test_single_word(input bit sel, input logic [W-1:0] word);
        int gap;
        logic [4:0] e, o;
        gap = sel ? GB : GA;
        drive(sel, 1'b1, word);
        @(posedge clk); #1;
        drive(sel, 1'b0, word);
        for (int c = 1; c <= L + gap + 1; c++) begin
            if (c <= W)
                e = {(gap == 0 && c == L), word[W-c], 1'b1, 1'b1, (c == W && PAR == 0)};
            else if (c == L)
                e = {(gap == 0), ^word, 1'b0, 1'b1, 1'b1};
            else if (c <= L + gap)
                e = 5'b00010;
            else
                e = 5'b10000;
            o = obs(sel);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single sel=%0d word=%b cyc=%0d {rdy,dout,bv,busy,done} got=%b exp=%b",
                         sel, word, c, o, e);
            end
            if (c < L + gap + 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        logic [4:0] e, o;
        int k, p;
        words[0] = 5'b10010;
        words[1] = 5'b01101;
        drive(1'b1, 1'b1, words[0]);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, words[1]);
        for (int c = 1; c <= 2 * L + 1; c++) begin
            k = (c - 1) / L;
            p = (c - 1) % L;
            if (c == 2 * L + 1)
                e = 5'b10000;
            else if (p < W)
                e = {(p == L - 1), words[k][W-1-p], 1'b1, 1'b1, (p == L - 1)};
            else
                e = {1'b1, ^words[k], 1'b0, 1'b1, 1'b1};
            o = obs(1'b1);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b cyc=%0d {rdy,dout,bv,busy,done} got=%b exp=%b", c, o, e);
            end
            if (c == L + 1) drive(1'b1, 1'b0, words[1]);
            if (c < 2 * L + 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Model: each accepted word appends its expected per-cycle outputs to a queue; one entry retires per clock.
    task automatic test_random(input bit sel, input int n, input int pct,
                               input bit fixed, input logic [W-1:0] fword);
        ent_t q[$];
        logic [W-1:0] w;
        logic vld, keep;
        bit acc, rdy_m;
        int gap;
        logic [4:0] e, o;
        gap = sel ? GB : GA;
        vld = 1'b0; w = '0; acc = 1'b0;
        for (int c = 0; c < n + 2 * (L + gap + 2); c++) begin
            @(posedge clk);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--)
                    q.push_back(ent_t'({w[i], 1'b1, (i == 0 && PAR == 0)}));
                if (PAR == 1) q.push_back(ent_t'({^w, 1'b0, 1'b1}));
                for (int g = 0; g < gap; g++) q.push_back(ent_t'(3'b000));
            end
            #1;
            rdy_m = (q.size() == 0) || (gap == 0 && q.size() == 1);
            if (q.size() != 0) e = {rdy_m, q[0].d, q[0].v, 1'b1, q[0].dn};
            else               e = {rdy_m, 4'b0000};
            o = obs(sel);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rand sel=%0d cyc=%0d {rdy,dout,bv,busy,done} got=%b exp=%b", sel, c, o, e);
            end
            keep = vld && !acc;
            if (!keep) begin
                vld = (c < n) && ($urandom_range(99) < pct);
                w   = fixed ? fword : W'($urandom);
            end
            acc = vld && rdy_m;
            drive(sel, vld, w);
        end
        drive(sel, 1'b0, w);
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 5'b10010);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'b10010);
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (obs(1'b0) !== 5'b00110) begin
            bad++;
            $display("FAIL pre_reset_bit3 got=%b exp=%b", obs(1'b0), 5'b00110);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs(1'b0) !== 5'b10000) begin
            bad++;
            $display("FAIL async_reset got=%b exp=%b", obs(1'b0), 5'b10000);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_single_word(1'b0, 5'b10110);
    endtask

    initial begin
        test_reset();
        test_single_word(1'b0, PATTERN_10010);
        test_single_word(1'b0, 5'b10011);
        test_single_word(1'b1, 5'b10011);
        test_back_to_back();
        test_random(1'b0, 60, 100, 1'b1, 5'b11111);
        test_random(1'b0, 300, 60, 1'b0, '0);
        test_random(1'b1, 300, 70, 1'b0, '0);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
